// File: rtl/key_debounce_array_pkg.sv
// rtl/key_debounce_array_pkg.sv - shared LED mode encodings for the key bank front end
package key_debounce_array_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE      = 2'd0,
        MODE_FOLLOW      = 2'd1,
        MODE_LONG_TOGGLE = 2'd2,
        MODE_OFF         = 2'd3
    } led_mode_e;

endpackage

// File: rtl/key_debounce_array_ch.sv
// rtl/key_debounce_array_ch.sv - one key: synchroniser, debounce, hold counter, event pulses
module key_debounce_array_ch #(
    parameter int DEBOUNCE_CYC   = 10000,
    parameter int LONG_CYC       = 500000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic keyin_i,
    output logic key_state_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic long_pulse_o
);

    localparam int   DW      = $clog2(DEBOUNCE_CYC);
    localparam int   LW      = $clog2(LONG_CYC + 1);
    localparam logic KEY_INV = (KEY_ACTIVE_LOW != 0);

    logic          sync1_q, sync2_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [LW-1:0] hold_cnt_q, hold_cnt_d;
    logic          key_state_q, key_state_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          level;

    assign level = sync2_q ^ KEY_INV;

    always_comb begin
        deb_cnt_d   = deb_cnt_q;
        key_state_d = key_state_q;
        hold_cnt_d  = hold_cnt_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        // Any sample agreeing with the accepted level restarts the stability window.
        if (level != key_state_q) begin
            if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
                key_state_d = level;
                deb_cnt_d   = '0;
                press_d     = level;
                release_d   = ~level;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end else begin
            deb_cnt_d = '0;
        end

        // A release accepted this cycle wins over a long press landing on the same edge.
        if (!key_state_q || release_d) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q < LW'(LONG_CYC)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            long_d     = (hold_cnt_q == LW'(LONG_CYC - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= KEY_INV;
            sync2_q     <= KEY_INV;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            key_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync1_q     <= keyin_i;
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            key_state_q <= key_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign key_state_o     = key_state_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;

endmodule

// File: rtl/key_debounce_array.sv
// rtl/key_debounce_array.sv - N-key bank: per-key debounce channels plus LED mode logic
module key_debounce_array
    import key_debounce_array_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int DEBOUNCE_CYC   = 10000,
    parameter int LONG_CYC       = 500000,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] keyin,
    input  logic [1:0]        mode,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] led
);

    localparam logic LED_INV = (LED_ACTIVE_LOW != 0);

    logic [N_KEYS-1:0] tgl_q, tgl_d;
    logic [N_KEYS-1:0] lit_q, lit_d;
    led_mode_e         mode_sel;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_array_ch #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .LONG_CYC      (LONG_CYC),
            .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
        ) u_ch (
            .clk            (clk),
            .rst            (rst),
            .keyin_i        (keyin[g]),
            .key_state_o    (key_state[g]),
            .press_pulse_o  (press_pulse[g]),
            .release_pulse_o(release_pulse[g]),
            .long_pulse_o   (long_pulse[g])
        );
    end

    assign mode_sel = led_mode_e'(mode);

    // FOLLOW leaves the toggle state untouched so switching back restores it.
    always_comb begin
        tgl_d = tgl_q;
        lit_d = lit_q;
        case (mode_sel)
            MODE_TOGGLE: begin
                tgl_d = tgl_q ^ press_pulse;
                lit_d = tgl_d;
            end
            MODE_FOLLOW: begin
                lit_d = key_state;
            end
            MODE_LONG_TOGGLE: begin
                tgl_d = tgl_q ^ long_pulse;
                lit_d = tgl_d;
            end
            default: begin
                tgl_d = '0;
                lit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgl_q <= '0;
            lit_q <= '0;
        end else begin
            tgl_q <= tgl_d;
            lit_q <= lit_d;
        end
    end

    assign led = lit_q ^ {N_KEYS{LED_INV}};

endmodule

// File: tb/tb_key_debounce_array.sv
// tb/tb_key_debounce_array.sv - scoreboard bench for key_debounce_array
module tb_key_debounce_array;

    localparam int N    = 4;
    localparam int DEB  = 4;
    localparam int LNG  = 16;
    localparam int MAXC = 8192;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] keyin;
    logic [1:0]   mode;
    logic [N-1:0] key_state, press_pulse, release_pulse, long_pulse, led;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_debounce_array #(
        .N_KEYS        (N),
        .DEBOUNCE_CYC  (DEB),
        .LONG_CYC      (LNG),
        .KEY_ACTIVE_LOW(1),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keyin        (keyin),
        .mode         (mode),
        .key_state    (key_state),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .led          (led)
    );

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] ks;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
        logic [N-1:0] lg;
        logic [N-1:0] led;
    } exp_t;

    exp_t         expq[$];
    logic [N-1:0] pin_hist[MAXC];
    int           edge_n   = 0;
    int           last_rst = -1000;
    int           last_acc[N];
    int           press_edge[N];
    logic [N-1:0] m_ks = '0, m_pr = '0, m_rl = '0, m_lg = '0, m_tgl = '0, m_lit = '0;

    // Pressed level of key k as seen by the debouncer at edge t (pins take two edges to arrive).
    function automatic logic sample_at(int t, int k);
        if (t >= 2 && t - 2 > last_rst) return pin_hist[t-2][k];
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [N-1:0] n_ks, n_pr, n_rl, n_lg;
        logic         acc;
        exp_t         e;
        pin_hist[edge_n] = ~keyin;
        if (rst) begin
            last_rst = edge_n;
            m_ks = '0; m_pr = '0; m_rl = '0; m_lg = '0; m_tgl = '0; m_lit = '0;
        end else begin
            n_ks = m_ks; n_pr = '0; n_rl = '0; n_lg = '0;
            for (int k = 0; k < N; k++) begin
                acc = (edge_n - DEB + 1 > last_rst) && (edge_n - DEB + 1 > last_acc[k]);
                for (int j = 0; j < DEB; j++)
                    if (sample_at(edge_n - j, k) == m_ks[k]) acc = 1'b0;
                if (acc) begin
                    n_ks[k]     = ~m_ks[k];
                    n_pr[k]     = n_ks[k];
                    n_rl[k]     = m_ks[k];
                    last_acc[k] = edge_n;
                    if (n_ks[k]) press_edge[k] = edge_n;
                end else if (m_ks[k] && edge_n - press_edge[k] == LNG) begin
                    n_lg[k] = 1'b1;
                end
            end
            case (mode)
                2'd0: begin m_tgl = m_tgl ^ m_pr; m_lit = m_tgl; end
                2'd1: m_lit = m_ks;
                2'd2: begin m_tgl = m_tgl ^ m_lg; m_lit = m_tgl; end
                default: begin m_tgl = '0; m_lit = '0; end
            endcase
            m_ks = n_ks; m_pr = n_pr; m_rl = n_rl; m_lg = n_lg;
        end
        e.cyc = 32'(edge_n);
        e.ks  = m_ks;
        e.pr  = m_pr;
        e.rl  = m_rl;
        e.lg  = m_lg;
        e.led = ~m_lit;
        expq.push_back(e);
        edge_n++;
    endtask

    task automatic chk(input string nm, input int c, input logic [N-1:0] act, input logic [N-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b exp=%b", nm, c, act, exp_v);
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            last_acc[k]   = -1000;
            press_edge[k] = -1000;
        end
        forever begin
            @(posedge clk);
            if (edge_n < MAXC) model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("key_state", int'(e.cyc), key_state, e.ks);
                chk("press_pulse", int'(e.cyc), press_pulse, e.pr);
                chk("release_pulse", int'(e.cyc), release_pulse, e.rl);
                chk("long_pulse", int'(e.cyc), long_pulse, e.lg);
                chk("led", int'(e.cyc), led, e.led);
            end
        end
    end

    task automatic drive(input logic [N-1:0] pv, input int n);
        keyin = ~pv;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int           run[N];
        logic [N-1:0] cur;
        rst   = 1'b1;
        mode  = 2'd0;
        keyin = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive('0, 5);
        drive(4'b0001, 10); drive('0, 10);
        drive(4'b0001, DEB - 1); drive('0, 8);
        drive(4'b0001, DEB); drive('0, 10);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0010, 2);
            drive('0, 2);
        end
        drive(4'b0010, 12); drive('0, 10);
        mode = 2'd2;
        drive(4'b0100, 30); drive('0, 10);
        drive(4'b0100, 10); drive('0, 10);
        mode = 2'd1;
        drive(4'b1000, 8); drive('0, 8);
        mode = 2'd0;
        drive('0, 5);
        drive('1, 20); drive('0, 20);
        drive(4'b0001, 15);
        rst = 1'b1; drive(4'b0001, 2);
        rst = 1'b0; drive(4'b0001, 25);
        drive('0, 10);

        cur = '0;
        for (int k = 0; k < N; k++) run[k] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (run[k] == 0) begin
                    cur[k] = ~cur[k];
                    run[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 40));
                end
                run[k]--;
            end
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 399) == 0);
            drive(cur, 1);
        end
        rst = 1'b0;
        drive('0, 12);
        repeat (2) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
